// File: rtl/id_operand_fetch.sv
// RV32I decode/operand-fetch stage: drives regfile read addresses, builds the immediate and presents operands to execute.
// Optional bypass network enabled by `define ID_OPFETCH_FWD_EN; without it, writeback hazards stall in FETCH.
module id_operand_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic [4:0]  o_raddr1,
  output logic [4:0]  o_raddr2,
  input  logic [31:0] i_rdata1,
  input  logic [31:0] i_rdata2,
  input  logic        i_wb_we,
  input  logic [4:0]  i_wb_waddr,
  input  logic [31:0] i_wb_wdata,
  output logic        o_valid,
  input  logic        i_ex_ready,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output logic [31:0] o_rs1_val,
  output logic [31:0] o_rs2_val,
  output logic [4:0]  o_rd,
  output logic [31:0] o_imm
);

  typedef enum logic [1:0] {S_EMPTY, S_FETCH, S_FULL} state_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic        hit1_q, hit1_d;
  logic        hit2_q, hit2_d;

  logic [4:0]  rs1, rs2;
  logic        wb1_now, wb2_now;
  logic        stall, accept;
  logic [31:0] fetch1, fetch2, full1, full2;

  function automatic logic [31:0] imm_gen(input logic [31:0] ins);
    logic [31:0] imm;
    case (ins[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: imm = {{20{ins[31]}}, ins[31:20]};
      7'b0100011: imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      7'b1100011: imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      7'b0110111, 7'b0010111: imm = {ins[31:12], 12'b0};
      7'b1101111: imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

  assign rs1 = instr_q[19:15];
  assign rs2 = instr_q[24:20];
  // Writebacks to x0 never count as a hit.
  assign wb1_now = i_wb_we && (i_wb_waddr == rs1) && (rs1 != 5'd0);
  assign wb2_now = i_wb_we && (i_wb_waddr == rs2) && (rs2 != 5'd0);

`ifdef ID_OPFETCH_FWD_EN
  logic [31:0] hdat1_q, hdat1_d;
  logic [31:0] hdat2_q, hdat2_d;

  assign stall  = 1'b0;
  assign fetch1 = (rs1 == 5'd0) ? 32'd0 : wb1_now ? i_wb_wdata : hit1_q ? hdat1_q : i_rdata1;
  assign fetch2 = (rs2 == 5'd0) ? 32'd0 : wb2_now ? i_wb_wdata : hit2_q ? hdat2_q : i_rdata2;

  always_comb begin
    hdat1_d = hdat1_q;
    hdat2_d = hdat2_q;
    if (accept) begin
      hdat1_d = i_wb_wdata;
      hdat2_d = i_wb_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hdat1_q <= 32'd0;
      hdat2_q <= 32'd0;
    end else begin
      hdat1_q <= hdat1_d;
      hdat2_q <= hdat2_d;
    end
  end
`else
  // Regfile data is stale while any hit is outstanding; wait for a clean re-read.
  assign stall  = (state_q == S_FETCH) && (wb1_now || wb2_now || hit1_q || hit2_q);
  assign fetch1 = (rs1 == 5'd0) ? 32'd0 : i_rdata1;
  assign fetch2 = (rs2 == 5'd0) ? 32'd0 : i_rdata2;
`endif

  assign full1 = wb1_now ? i_wb_wdata : op1_q;
  assign full2 = wb2_now ? i_wb_wdata : op2_q;

  assign o_valid = !rst && (((state_q == S_FETCH) && !stall) || (state_q == S_FULL));
  assign o_ready = !rst && ((state_q == S_EMPTY) || (o_valid && i_ex_ready));
  assign accept  = i_valid && o_ready;

  assign o_raddr1 = accept ? i_instr[19:15] : rs1;
  assign o_raddr2 = accept ? i_instr[24:20] : rs2;

  always_comb begin
    o_rs1_val = op1_q;
    o_rs2_val = op2_q;
    if (state_q == S_FETCH) begin
      o_rs1_val = fetch1;
      o_rs2_val = fetch2;
    end else if (state_q == S_FULL) begin
      o_rs1_val = full1;
      o_rs2_val = full2;
    end
  end

  assign o_pc    = pc_q;
  assign o_instr = instr_q;
  assign o_rd    = instr_q[11:7];
  assign o_imm   = imm_q;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    imm_d   = imm_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    hit1_d  = hit1_q;
    hit2_d  = hit2_q;
    case (state_q)
      S_EMPTY: state_d = S_EMPTY;
      S_FETCH: begin
        if (stall) begin
          hit1_d = wb1_now;
          hit2_d = wb2_now;
        end else if (i_ex_ready) begin
          state_d = S_EMPTY;
        end else begin
          state_d = S_FULL;
          op1_d   = fetch1;
          op2_d   = fetch2;
        end
      end
      S_FULL: begin
        if (i_ex_ready) begin
          state_d = S_EMPTY;
        end else begin
          op1_d = full1;
          op2_d = full2;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (accept) begin
      state_d = S_FETCH;
      instr_d = i_instr;
      pc_d    = i_pc;
      imm_d   = imm_gen(i_instr);
      hit1_d  = i_wb_we && (i_wb_waddr == i_instr[19:15]) && (i_instr[19:15] != 5'd0);
      hit2_d  = i_wb_we && (i_wb_waddr == i_instr[24:20]) && (i_instr[24:20] != 5'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      instr_q <= 32'd0;
      pc_q    <= 32'd0;
      imm_q   <= 32'd0;
      op1_q   <= 32'd0;
      op2_q   <= 32'd0;
      hit1_q  <= 1'b0;
      hit2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      hit1_q  <= hit1_d;
      hit2_q  <= hit2_d;
    end
  end

endmodule

// File: tb/tb_id_operand_fetch.sv
// Bench for id_operand_fetch: directed scenarios then random traffic against an architectural register model.
module tb_id_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, o_ready;
  logic [31:0] i_instr, i_pc;
  logic [4:0]  o_raddr1, o_raddr2;
  logic [31:0] i_rdata1, i_rdata2;
  logic        i_wb_we;
  logic [4:0]  i_wb_waddr;
  logic [31:0] i_wb_wdata;
  logic        o_valid, i_ex_ready;
  logic [31:0] o_pc, o_instr, o_rs1_val, o_rs2_val, o_imm;
  logic [4:0]  o_rd;

  id_operand_fetch dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_instr(i_instr), .i_pc(i_pc), .o_raddr1(o_raddr1), .o_raddr2(o_raddr2),
    .i_rdata1(i_rdata1), .i_rdata2(i_rdata2), .i_wb_we(i_wb_we),
    .i_wb_waddr(i_wb_waddr), .i_wb_wdata(i_wb_wdata), .o_valid(o_valid),
    .i_ex_ready(i_ex_ready), .o_pc(o_pc), .o_instr(o_instr),
    .o_rs1_val(o_rs1_val), .o_rs2_val(o_rs2_val), .o_rd(o_rd), .o_imm(o_imm)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_cons = 0;

  // Architectural register file; also serves the DUT's registered reads.
  logic [31:0] regs [32];
  logic [31:0] rd1n, rd2n;

  // The stage holds at most one instruction.
  logic        m_have, m_seen, m_hit;
  logic [31:0] m_instr, m_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] imm_ref(input logic [31:0] ins);
    logic [31:0] sgn;
    sgn = ins[31] ? 32'hFFFF_FFFF : 32'd0;
    case (ins[6:0])
      7'h13, 7'h03, 7'h67: return 32'($signed(ins) >>> 20);
      7'h23: return (32'($signed(ins) >>> 20) & 32'hFFFF_FFE0) | 32'(ins[11:7]);
      7'h63: return (sgn << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      7'h37, 7'h17: return ins & 32'hFFFF_F000;
      7'h6F: return (sgn << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic wbhit(input logic [31:0] ins);
    return i_wb_we && (i_wb_waddr != 5'd0) &&
           ((i_wb_waddr == ins[19:15]) || (i_wb_waddr == ins[24:20]));
  endfunction

  // Current architectural value, including a writeback landing this cycle.
  function automatic logic [31:0] opnd(input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
    if (i_wb_we && (i_wb_waddr == rs)) return i_wb_wdata;
    return regs[rs];
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic exr);
    i_valid = v; i_instr = ins; i_pc = pc;
    i_wb_we = we; i_wb_waddr = wa; i_wb_wdata = wd; i_ex_ready = exr;
  endtask

  task automatic sample();
    logic exp_v;
    #1;
    rd1n = regs[o_raddr1];
    rd2n = regs[o_raddr2];
    if (rst) begin
      chk("rst_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_ready", {31'd0, o_ready}, 32'd0);
      m_have = 1'b0;
      return;
    end
`ifdef ID_OPFETCH_FWD_EN
    exp_v = m_have;
`else
    exp_v = m_have && (m_seen || !(m_hit || wbhit(m_instr)));
`endif
    chk("valid", {31'd0, o_valid}, {31'd0, exp_v});
    chk("ready", {31'd0, o_ready}, {31'd0, !m_have || (o_valid && i_ex_ready)});
    if (i_valid && o_ready) begin
      chk("raddr1_acc", {27'd0, o_raddr1}, {27'd0, i_instr[19:15]});
      chk("raddr2_acc", {27'd0, o_raddr2}, {27'd0, i_instr[24:20]});
    end else if (m_have) begin
      chk("raddr1_hold", {27'd0, o_raddr1}, {27'd0, m_instr[19:15]});
      chk("raddr2_hold", {27'd0, o_raddr2}, {27'd0, m_instr[24:20]});
    end
    if (m_have && o_valid) begin
      chk("pc", o_pc, m_pc);
      chk("instr", o_instr, m_instr);
      chk("rd", {27'd0, o_rd}, {27'd0, m_instr[11:7]});
      chk("imm", o_imm, imm_ref(m_instr));
      chk("rs1_val", o_rs1_val, opnd(m_instr[19:15]));
      chk("rs2_val", o_rs2_val, opnd(m_instr[24:20]));
    end
    if (m_have && o_valid && i_ex_ready) begin
      m_have = 1'b0;
      n_cons++;
    end else if (m_have && o_valid) begin
      m_seen = 1'b1;
    end else if (m_have) begin
      m_hit = wbhit(m_instr);
    end
    if (i_valid && o_ready) begin
      m_have = 1'b1; m_instr = i_instr; m_pc = i_pc;
      m_seen = 1'b0; m_hit = wbhit(i_instr);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    i_rdata1 = rd1n;
    i_rdata2 = rd2n;
    if (i_wb_we && (i_wb_waddr != 5'd0)) regs[i_wb_waddr] = i_wb_wdata;
    @(negedge clk);
  endtask

  task automatic post_reset_chk();
    chk("pr_valid", {31'd0, o_valid}, 32'd0);
    chk("pr_ready", {31'd0, o_ready}, 32'd1);
    chk("pr_pc", o_pc, 32'd0);
    chk("pr_instr", o_instr, 32'd0);
    chk("pr_rs1", o_rs1_val, 32'd0);
    chk("pr_rs2", o_rs2_val, 32'd0);
    chk("pr_rd", {27'd0, o_rd}, 32'd0);
    chk("pr_imm", o_imm, 32'd0);
    chk("pr_raddr", {22'd0, o_raddr1, o_raddr2}, 32'd0);
  endtask

  logic [6:0] ops [12] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37,
                           7'h17, 7'h6F, 7'h33, 7'h73, 7'h0F, 7'h00};

  initial begin
    int cons0;
    logic [31:0] r;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    m_have = 1'b0; m_seen = 1'b0; m_hit = 1'b0; m_instr = 32'd0; m_pc = 32'd0;
    rd1n = 32'd0; rd2n = 32'd0; i_rdata1 = 32'd0; i_rdata2 = 32'd0;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    repeat (2) begin sample(); advance(); end
    rst = 1'b0;
    sample(); post_reset_chk(); advance();

    regs[1] = 32'h10; regs[2] = 32'h20;
    // addi x5,x1,-4
    drive(1, 32'hFFC08293, 32'h100, 0, 0, 0, 0); sample(); advance();
    drive(0, 0, 0, 0, 0, 0, 1); sample();
    chk("addi_valid", {31'd0, o_valid}, 32'd1);
    chk("addi_rs1", o_rs1_val, 32'h10);
    chk("addi_imm", o_imm, 32'hFFFF_FFFC);
    chk("addi_rd", {27'd0, o_rd}, 32'd5);
    advance();

    // addi x6,x1,1 with writeback x1=0xAB on the accept edge
    drive(1, 32'h00108313, 32'h104, 1, 5'd1, 32'hAB, 1); sample(); advance();
    drive(0, 0, 0, 0, 0, 0, 1); sample();
`ifdef ID_OPFETCH_FWD_EN
    chk("fwd_valid", {31'd0, o_valid}, 32'd1);
    chk("fwd_rs1", o_rs1_val, 32'hAB);
    advance();
`else
    chk("stall_valid", {31'd0, o_valid}, 32'd0);
    advance();
    sample();
    chk("stall_valid2", {31'd0, o_valid}, 32'd1);
    chk("stall_rs1", o_rs1_val, 32'hAB);
    advance();
`endif

    // add x7,x1,x2 held in FULL; x2 written during the hold
    drive(1, 32'h002083B3, 32'h108, 0, 0, 0, 0); sample(); advance();
    drive(0, 0, 0, 0, 0, 0, 0); sample(); advance();
    drive(0, 0, 0, 1, 5'd2, 32'h55, 0); sample();
    chk("hold_rs2_now", o_rs2_val, 32'h55);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0); sample();
    chk("hold_rs2", o_rs2_val, 32'h55);
    chk("hold_pc", o_pc, 32'h108);
    chk("hold_instr", o_instr, 32'h002083B3);
    advance();
    drive(0, 0, 0, 0, 0, 0, 1); sample(); advance();

    // Back-to-back stream of four
    cons0 = n_cons;
    for (int i = 0; i < 5; i++) begin
      r = $urandom;
      drive(i < 4, {r[31:7], 7'h13}, 32'h200 + 32'(4 * i), 0, 0, 0, 1);
      sample();
      if (i > 0) begin
        chk("b2b_valid", {31'd0, o_valid}, 32'd1);
        chk("b2b_pc", o_pc, 32'h200 + 32'(4 * (i - 1)));
      end
      advance();
    end
    chk("b2b_count", n_cons, cons0 + 4);

    // add x8,x0,x0 while writebacks target x0
    drive(1, 32'h00000433, 32'h300, 1, 5'd0, 32'hFF, 0); sample(); advance();
    drive(0, 0, 0, 1, 5'd0, 32'hFF, 1); sample();
    chk("x0_valid", {31'd0, o_valid}, 32'd1);
    chk("x0_rs1", o_rs1_val, 32'd0);
    chk("x0_rs2", o_rs2_val, 32'd0);
    advance();

    // Reset while FULL
    drive(1, 32'hFFC08293, 32'h400, 0, 0, 0, 0); sample(); advance();
    drive(0, 0, 0, 0, 0, 0, 0); sample(); advance();
    sample(); chk("full_valid", {31'd0, o_valid}, 32'd1); advance();
    rst = 1'b1; sample(); advance();
    rst = 1'b0; sample(); post_reset_chk(); advance();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      r = $urandom;
      drive($urandom_range(0, 9) < 7,
            {r[31:25], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), r[14:7],
             ops[$urandom_range(0, 11)]},
            $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
            $urandom_range(0, 9) < 7);
      sample();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
